// File: rtl/xy_dac_serializer.sv
`default_nettype none
// =============================================================================
// xy_dac_serializer : clamps XY points, buffers them and drives a dual 12-bit
// SPI DAC (X on A, Y on B, then LDAC). Option macro: XY_DAC_INVERT_Y_EN.
// Revision: 1.0
// =============================================================================
module xy_dac_serializer #(
  parameter int IN_WIDTH   = 9,
  parameter int DAC_BITS   = 8,
  parameter int FRAME_MIN  = 0,
  parameter int FRAME_MAX  = 255,
  parameter int FIFO_DEPTH = 16,
  parameter int SCLK_DIV   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [IN_WIDTH-1:0] x,
  input  logic signed [IN_WIDTH-1:0] y,
  input  logic                       drawing,
  input  logic                       vector_reset,
  output logic                       dac_sclk,
  output logic                       dac_mosi,
  output logic                       dac_cs_n,
  output logic                       dac_ldac_n,
  output logic                       blank,
  output logic                       full,
  output logic                       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(SCLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

`ifdef XY_DAC_INVERT_Y_EN
  localparam logic INV_Y = 1'b1;
`else
  localparam logic INV_Y = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT_X = 3'd1,
    S_GAP     = 3'd2,
    S_SHIFT_Y = 3'd3,
    S_HOLD    = 3'd4,
    S_LATCH   = 3'd5
  } state_t;

  function automatic logic [11:0] to_code(input int v, input logic mirror);
    int c;
    c = v;
    if (c < FRAME_MIN)      c = FRAME_MIN;
    else if (c > FRAME_MAX) c = FRAME_MAX;
    if (mirror) c = FRAME_MAX - (c - FRAME_MIN);
    return 12'(DAC_BITS'(c)) << (12 - DAC_BITS);
  endfunction

  logic [11:0] code_x, code_y;
  assign code_x = to_code(int'(x), 1'b0);
  assign code_y = to_code(int'(y), INV_Y);

  logic [23:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, overflow_q, overflow_d, pending_q, pending_d;
  logic          push, drop, pop;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    half_q, half_d;
  logic [15:0]   shreg_q, shreg_d;
  logic [11:0]   ycode_q, ycode_d;
  logic          cs_n_q, cs_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic          ldac_n_q, ldac_n_d, blank_q, blank_d;

  // The line drawer cannot stall, so a point arriving while full is lost.
  always_comb begin
    push       = drawing & ~full_q;
    drop       = drawing & full_q;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    full_d     = (count_d == DEPTH_C);
    overflow_d = drop ? 1'b1 : (vector_reset ? 1'b0 : overflow_q);
    pending_d  = (count_q != '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {code_x, code_y};
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    half_d   = half_q;
    shreg_d  = shreg_q;
    ycode_d  = ycode_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    ldac_n_d = ldac_n_q;
    blank_d  = blank_q;
    pop      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          pop     = 1'b1;
          ycode_d = mem_q[rd_ptr_q][11:0];
          shreg_d = {4'b0011, mem_q[rd_ptr_q][23:12]};
          mosi_d  = 1'b0;
          cs_n_d  = 1'b0;
          div_d   = '0;
          half_d  = '0;
          state_d = S_SHIFT_X;
        end
      end
      S_SHIFT_X, S_SHIFT_Y: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          half_d = half_q + 5'd1;
          if (!half_q[0]) begin
            sclk_d = 1'b1;
          end else begin
            // Falling SCLK: present the next bit, or close the word after bit 0.
            sclk_d = 1'b0;
            if (half_q == 5'd31) begin
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              state_d = (state_q == S_SHIFT_X) ? S_GAP : S_HOLD;
            end else begin
              shreg_d = {shreg_q[14:0], 1'b0};
              mosi_d  = shreg_q[14];
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_GAP: begin
        if (div_q == DW'(1)) begin
          div_d   = '0;
          half_d  = '0;
          shreg_d = {4'b1011, ycode_q};
          mosi_d  = 1'b1;
          cs_n_d  = 1'b0;
          state_d = S_SHIFT_Y;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_HOLD: begin
        ldac_n_d = 1'b0;
        blank_d  = 1'b0;
        state_d  = S_LATCH;
      end
      S_LATCH: begin
        ldac_n_d = 1'b1;
        if (count_q == '0) blank_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      pending_q  <= 1'b0;
      state_q    <= S_IDLE;
      div_q      <= '0;
      half_q     <= '0;
      shreg_q    <= '0;
      ycode_q    <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ldac_n_q   <= 1'b1;
      blank_q    <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      pending_q  <= pending_d;
      state_q    <= state_d;
      div_q      <= div_d;
      half_q     <= half_d;
      shreg_q    <= shreg_d;
      ycode_q    <= ycode_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ldac_n_q   <= ldac_n_d;
      blank_q    <= blank_d;
    end
  end

  assign dac_sclk   = sclk_q;
  assign dac_mosi   = mosi_q;
  assign dac_cs_n   = cs_n_q;
  assign dac_ldac_n = ldac_n_q;
  assign blank      = blank_q;
  assign full       = full_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_xy_dac_serializer.sv
`default_nettype none
// =============================================================================
// tb_xy_dac_serializer : scoreboard bench; instance 0 uses defaults,
// instance 1 uses FRAME_MAX=200. Honours XY_DAC_INVERT_Y_EN. Revision: 1.0
// =============================================================================
module tb_xy_dac_serializer;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic signed [8:0] x = '0, y = '0;
  logic              drawing = 1'b0, drawing_c = 1'b0;
  logic              vector_reset = 1'b0, vreset_c = 1'b0;
  logic [1:0]        sclk, mosi, cs_n, ldac_n, blank, full, ovf;

  xy_dac_serializer dut0 (
    .clk(clk), .rst(rst), .x(x), .y(y), .drawing(drawing), .vector_reset(vector_reset),
    .dac_sclk(sclk[0]), .dac_mosi(mosi[0]), .dac_cs_n(cs_n[0]), .dac_ldac_n(ldac_n[0]),
    .blank(blank[0]), .full(full[0]), .overflow(ovf[0])
  );

  xy_dac_serializer #(.FRAME_MAX(200)) dut1 (
    .clk(clk), .rst(rst), .x(x), .y(y), .drawing(drawing_c), .vector_reset(vreset_c),
    .dac_sclk(sclk[1]), .dac_mosi(mosi[1]), .dac_cs_n(cs_n[1]), .dac_ldac_n(ldac_n[1]),
    .blank(blank[1]), .full(full[1]), .overflow(ovf[1])
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SPI receiver: words are tagged with their bit count in the upper half.
  logic [1:0]  p_cs = 2'b11, p_sclk = 2'b00, p_ldac = 2'b11, p_blank = 2'b11;
  int          bits [2];
  logic [15:0] sh [2];
  logic [31:0] rxq0 [$], rxq1 [$], exq [$];
  int          t_fall [$], t_rise [$];
  int          ldac_cnt = 0, t_ldac_fall = -1, t_ldac_rise = -1;
  int          t_blank_fall = -1, t_blank_rise = -1;

  initial begin
    bits[0] = 0; bits[1] = 0; sh[0] = '0; sh[1] = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst) begin
          bits[i] = 0;
        end else begin
          if (!cs_n[i] && !p_sclk[i] && sclk[i]) begin
            sh[i] = {sh[i][14:0], mosi[i]};
            bits[i]++;
          end
          if (!p_cs[i] && cs_n[i]) begin
            if (i == 0) begin
              rxq0.push_back({16'(bits[i]), sh[i]});
              t_rise.push_back(cyc);
            end else begin
              rxq1.push_back({16'(bits[i]), sh[i]});
            end
            bits[i] = 0;
          end
          if (i == 0) begin
            if (p_cs[0] && !cs_n[0])     t_fall.push_back(cyc);
            if (p_ldac[0] && !ldac_n[0]) begin ldac_cnt++; t_ldac_fall = cyc; end
            if (!p_ldac[0] && ldac_n[0]) t_ldac_rise = cyc;
            if (p_blank[0] && !blank[0]) t_blank_fall = cyc;
            if (!p_blank[0] && blank[0]) t_blank_rise = cyc;
          end
        end
        p_cs[i] = cs_n[i]; p_sclk[i] = sclk[i]; p_ldac[i] = ldac_n[i]; p_blank[i] = blank[i];
      end
    end
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (rxq0.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("word_timeout", 32'(rxq0.size() >= n), 32'd1);
  endtask

  task automatic compare_words(input string tag);
    while (exq.size() > 0) begin
      if (rxq0.size() == 0) begin
        check({tag, "_missing"}, 32'hFFFF_FFFF, exq.pop_front());
      end else begin
        check(tag, rxq0.pop_front(), exq.pop_front());
      end
    end
  endtask

  function automatic logic [11:0] conv(input int v, input int fmax, input bit is_y);
    int c;
    c = (v < 0) ? 0 : ((v > fmax) ? fmax : v);
`ifdef XY_DAC_INVERT_Y_EN
    if (is_y) c = fmax - c;
`endif
    return 12'(c) << 4;
  endfunction

  localparam logic [31:0] TAG16 = 32'h0010_0000;
`ifdef XY_DAC_INVERT_Y_EN
  localparam logic [31:0] Y90 = 32'hBA50, Y250_D0 = 32'hB050, Y250_D1 = 32'hB000, Y20 = 32'hBEB0;
`else
  localparam logic [31:0] Y90 = 32'hB5A0, Y250_D0 = 32'hBFA0, Y250_D1 = 32'hBC80, Y20 = 32'hB140;
`endif

  int n0, base, k;

  initial begin
    repeat (3) tick();
    check("rst_cs_n", 32'(cs_n[0]), 32'd1);
    check("rst_ldac_n", 32'(ldac_n[0]), 32'd1);
    check("rst_sclk", 32'(sclk[0]), 32'd0);
    check("rst_mosi", 32'(mosi[0]), 32'd0);
    check("rst_blank", 32'(blank[0]), 32'd1);
    check("rst_full", 32'(full[0]), 32'd0);
    check("rst_overflow", 32'(ovf[0]), 32'd0);
    rst = 1'b1;
    repeat (2) tick();

    // Single point with full timing of the frame.
    t_fall.delete(); t_rise.delete();
    x = 150; y = 90; drawing = 1'b1; n0 = cyc + 1;
    tick();
    drawing = 1'b0;
    wait_words(2, 400);
    exq.push_back(TAG16 | 32'h3960);
    exq.push_back(TAG16 | Y90);
    compare_words("single_word");
    repeat (6) tick();
    check("csx_fall", 32'(t_fall[0] - n0), 32'd2);
    check("csx_rise", 32'(t_rise[0] - n0), 32'd66);
    check("csy_fall", 32'(t_fall[1] - n0), 32'd68);
    check("csy_rise", 32'(t_rise[1] - n0), 32'd132);
    check("ldac_fall", 32'(t_ldac_fall - n0), 32'd133);
    check("ldac_rise", 32'(t_ldac_rise - n0), 32'd134);
    check("blank_fall", 32'(t_blank_fall - n0), 32'd133);
    check("blank_rise", 32'(t_blank_rise - n0), 32'd134);
    check("ldac_count1", 32'(ldac_cnt), 32'd1);

    // Clamping on both instances.
    x = -5; y = 250; drawing = 1'b1; drawing_c = 1'b1;
    tick();
    drawing = 1'b0; drawing_c = 1'b0;
    wait_words(2, 400);
    exq.push_back(TAG16 | 32'h3000);
    exq.push_back(TAG16 | Y250_D0);
    compare_words("clamp_d0");
    check("clamp_d1_count", 32'(rxq1.size()), 32'd2);
    check("clamp_d1_x", rxq1.pop_front(), TAG16 | 32'h3000);
    check("clamp_d1_y", rxq1.pop_front(), TAG16 | Y250_D1);
    repeat (6) tick();
    check("idle_blank", 32'(blank[0]), 32'd1);

    // Burst of 20 points: 17 accepted, 3 dropped.
    base = ldac_cnt;
    for (int i = 0; i < 20; i++) begin
      x = 9'(i * 15 - 40); y = 9'(255 - i * 13); drawing = 1'b1;
      if (i < 17) begin
        exq.push_back(TAG16 | {20'h00003, conv(i * 15 - 40, 255, 1'b0)});
        exq.push_back(TAG16 | {20'h0000B, conv(255 - i * 13, 255, 1'b1)});
      end
      tick();
      check($sformatf("burst_full_%0d", i + 1), 32'(full[0]), 32'(i >= 16));
    end
    drawing = 1'b0;
    check("burst_overflow", 32'(ovf[0]), 32'd1);
    vector_reset = 1'b1;
    tick();
    vector_reset = 1'b0;
    check("vreset_clear", 32'(ovf[0]), 32'd0);
    check("vreset_keeps_fifo", 32'(full[0]), 32'd1);
    vector_reset = 1'b1; drawing = 1'b1;
    tick();
    vector_reset = 1'b0; drawing = 1'b0;
    check("vreset_set_wins", 32'(ovf[0]), 32'd1);
    wait_words(34, 17 * 133 + 300);
    compare_words("burst_word");
    repeat (6) tick();
    check("burst_ldac", 32'(ldac_cnt - base), 32'd17);
    check("overflow_sticky", 32'(ovf[0]), 32'd1);
    check("burst_drained", 32'(full[0]), 32'd0);

    // Reset in the middle of the X word.
    base = ldac_cnt;
    x = 100; y = 100; drawing = 1'b1;
    tick();
    drawing = 1'b0;
    k = 0;
    while (bits[0] < 7 && k < 200) begin tick(); k++; end
    check("reach_bit7", 32'(bits[0] >= 7), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_cs_n", 32'(cs_n[0]), 32'd1);
    check("mid_rst_sclk", 32'(sclk[0]), 32'd0);
    check("mid_rst_blank", 32'(blank[0]), 32'd1);
    check("mid_rst_mosi", 32'(mosi[0]), 32'd0);
    check("mid_rst_overflow", 32'(ovf[0]), 32'd0);
    repeat (4) tick();
    rst = 1'b1;
    repeat (150) tick();
    check("mid_rst_no_ldac", 32'(ldac_cnt - base), 32'd0);
    check("mid_rst_no_word", 32'(rxq0.size()), 32'd0);
    rxq0.delete();
    x = 10; y = 20; drawing = 1'b1;
    tick();
    drawing = 1'b0;
    wait_words(2, 400);
    exq.push_back(TAG16 | 32'h30A0);
    exq.push_back(TAG16 | Y20);
    compare_words("post_rst_word");
    repeat (6) tick();
    check("post_rst_ldac", 32'(ldac_cnt - base), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
